// File: rtl/alu_4_bit_driver_if.sv
// Command/response bus between the issuing control logic and alu_4_bit_driver.
// ALU_DRV_CHAIN_EN adds cmd_chain (reuse the previous result as operand 1).
interface alu_4_bit_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
`ifdef ALU_DRV_CHAIN_EN
  logic       cmd_chain;
`endif
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [2:0] rsp_op;

`ifdef ALU_DRV_CHAIN_EN
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_op
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_op
  );
`endif
endinterface

// File: rtl/alu_4_bit_driver.sv
// Front end for alu_4_bit: FIFO-buffered commands, registered ALU inputs, captured result.
// Optional ALU_DRV_CHAIN_EN: a command may take the last captured result as operand 1.
module alu_4_bit_driver #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_4_bit_driver_if.slave        cmd_if,
  output logic [2:0]               alu_op,
  output logic [3:0]               alu_in1,
  output logic [3:0]               alu_in2,
  input  logic [3:0]               alu_out,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef ALU_DRV_CHAIN_EN
  localparam int EW = 12;
`else
  localparam int EW = 11;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [3:0]    alu_in1_q, alu_in1_d;
  logic [3:0]    alu_in2_q, alu_in2_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [3:0]    rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_op_q, rsp_op_d;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;
  logic          cmd_ready;
  logic          push;
  logic          pop;
  logic          head_chain;

  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_if.cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr_q];

`ifdef ALU_DRV_CHAIN_EN
  assign entry_in   = {cmd_if.cmd_chain, cmd_if.cmd_op, cmd_if.cmd_a, cmd_if.cmd_b};
  assign head_chain = head[11];
`else
  assign entry_in   = {cmd_if.cmd_op, cmd_if.cmd_a, cmd_if.cmd_b};
  assign head_chain = 1'b0;
`endif

  // Storage only; occupancy lives in count_q so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= entry_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    alu_op_d    = alu_op_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d  = alu_out;
        rsp_op_d    = alu_op_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (cmd_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // In HOLD rsp_data_q is the result being handed off, i.e. the latest one.
    if (pop) begin
      alu_op_d  = head[10:8];
      alu_in1_d = head_chain ? rsp_data_q : head[7:4];
      alu_in2_d = head[3:0];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_op_q    <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_op_q    <= alu_op_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
    end
  end

  assign cmd_if.cmd_ready = cmd_ready;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;
  assign cmd_if.rsp_op    = rsp_op_q;
  assign alu_op           = alu_op_q;
  assign alu_in1          = alu_in1_q;
  assign alu_in2          = alu_in2_q;
  assign busy             = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_alu_4_bit_driver.sv
// Directed bench for alu_4_bit_driver with a behavioural 4-bit ALU attached.
// Chain checks are compiled in when ALU_DRV_CHAIN_EN is defined.
module tb_alu_4_bit_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] alu_op;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [3:0] alu_out;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_4_bit_driver_if bus ();

  alu_4_bit_driver #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_if  (bus),
    .alu_op  (alu_op),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_out (alu_out),
    .busy    (busy)
  );

  // Reference ALU: 000 add, 001 not b, 010 sub, 011 and, 100 or, 101 xor, 110 eq, 111 lt
  always_comb begin
    alu_out = 4'h0;
    case (alu_op)
      3'b000: alu_out = alu_in1 + alu_in2;
      3'b001: alu_out = ~alu_in2;
      3'b010: alu_out = alu_in1 - alu_in2;
      3'b011: alu_out = alu_in1 & alu_in2;
      3'b100: alu_out = alu_in1 | alu_in2;
      3'b101: alu_out = alu_in1 ^ alu_in2;
      3'b110: alu_out = {3'b000, alu_in1 == alu_in2};
      default: alu_out = {3'b000, alu_in1 < alu_in2};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_busy"},      busy,          0);
    chk({tag, "_rsp_data"},  bus.rsp_data,  0);
    chk({tag, "_rsp_op"},    bus.rsp_op,    0);
    chk({tag, "_alu_op"},    alu_op,        0);
    chk({tag, "_alu_in1"},   alu_in1,       0);
    chk({tag, "_alu_in2"},   alu_in2,       0);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic ch);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
`ifdef ALU_DRV_CHAIN_EN
    bus.cmd_chain = ch;
`endif
    while (!bus.cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout_cmd_ready", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic recv(input logic [3:0] d, input logic [2:0] op, input string tag);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    chk({tag, "_data"},  bus.rsp_data,  d);
    chk({tag, "_op"},    bus.rsp_op,    op);
    step();
    bus.rsp_ready = 1'b0;
  endtask

  logic [2:0] bp_op  [6] = '{3'd0, 3'd0, 3'd6, 3'd0, 3'd0, 3'd0};
  logic [3:0] bp_a   [6] = '{4'd1, 4'd6, 4'd12, 4'd15, 4'd2, 4'd7};
  logic [3:0] bp_b   [6] = '{4'd2, 4'd3, 4'd5, 4'd15, 4'd2, 4'd8};
  logic [3:0] bp_exp [5] = '{4'd3, 4'd9, 4'd0, 4'd14, 4'd4};

  initial begin
    int acc;
    int got;
    int stale;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
`ifdef ALU_DRV_CHAIN_EN
    bus.cmd_chain = 1'b0;
`endif
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;

    #3;
    reset_vals("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    reset_vals("post_rst");

    // Latency: accept at E0, pop at E1, result valid after E2
    bus.rsp_ready = 1'b1;
    send(3'd0, 4'd3, 4'd5, 1'b0);
    chk("lat_e0_valid", bus.rsp_valid, 0);
    chk("lat_e0_busy", busy, 1);
    step();
    chk("lat_e1_valid", bus.rsp_valid, 0);
    chk("lat_e1_in1", alu_in1, 3);
    chk("lat_e1_in2", alu_in2, 5);
    chk("lat_e1_op", alu_op, 0);
    step();
    chk("lat_e2_valid", bus.rsp_valid, 1);
    chk("lat_e2_data", bus.rsp_data, 8);
    chk("lat_e2_op", bus.rsp_op, 0);
    step();
    chk("lat_e3_valid", bus.rsp_valid, 0);
    chk("lat_e3_busy", busy, 0);

    send(3'd0, 4'd9, 4'd9, 1'b0);
    recv(4'd2, 3'd0, "ovf_add");
    send(3'd6, 4'd7, 4'd7, 1'b0);
    recv(4'd1, 3'd6, "cmp_eq");
    send(3'd1, 4'd0, 4'b0101, 1'b0);
    recv(4'b1010, 3'd1, "op001");

    // Backpressure: 6 back-to-back offers, 5 absorbed
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = bp_op[i];
      bus.cmd_a     = bp_a[i];
      bus.cmd_b     = bp_b[i];
      if (bus.cmd_ready) acc++;
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_ready_low", bus.cmd_ready, 0);
    chk("bp_head_data", bus.rsp_data, 3);
    repeat (3) step();
    chk("bp_hold_valid", bus.rsp_valid, 1);
    chk("bp_hold_data", bus.rsp_data, 3);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_drain_valid", bus.rsp_valid, 1);
      chk("bp_drain_data", bus.rsp_data, bp_exp[k]);
      chk("bp_drain_op", bus.rsp_op, bp_op[k]);
      step();
      if (k < 4) begin
        chk("bp_gap_valid", bus.rsp_valid, 0);
        step();
      end
    end
    chk("bp_busy_end", busy, 0);
    chk("bp_valid_end", bus.rsp_valid, 0);

    // Wrap-around: 12 commands, rsp_ready toggling every cycle
    bus.rsp_ready = 1'b0;
    got = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(3'd0, 4'(i), 4'(2 * i + 1), 1'b0);
      end
      begin
        int cyc = 0;
        while (got < 12 && cyc < 300) begin
          bus.rsp_ready = cyc[0];
          if (bus.rsp_valid && bus.rsp_ready) begin
            chk("wrap_data", bus.rsp_data, (3 * got + 1) % 16);
            got++;
          end
          step();
          cyc++;
        end
        bus.rsp_ready = 1'b0;
      end
    join
    chk("wrap_count", got, 12);
    repeat (4) step();
    chk("wrap_no_dup", bus.rsp_valid, 0);
    chk("wrap_busy", busy, 0);

    // Reset while in HOLD with 3 queued
    bus.rsp_ready = 1'b0;
    send(3'd0, 4'd5, 4'd6, 1'b0);
    send(3'd0, 4'd1, 4'd1, 1'b0);
    send(3'd0, 4'd2, 4'd2, 1'b0);
    send(3'd0, 4'd3, 4'd3, 1'b0);
    chk("rst_pre_valid", bus.rsp_valid, 1);
    chk("rst_pre_data", bus.rsp_data, 11);
    chk("rst_pre_in1", alu_in1, 5);
    chk("rst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid) stale++;
    end
    chk("rst_no_stale", stale, 0);
    chk("rst_after_busy", busy, 0);
    bus.rsp_ready = 1'b0;

`ifdef ALU_DRV_CHAIN_EN
    send(3'd0, 4'd9, 4'd4, 1'b1);
    recv(4'd4, 3'd0, "chain_first");
    send(3'd0, 4'd3, 4'd5, 1'b0);
    recv(4'd8, 3'd0, "chain_base");
    send(3'd0, 4'd0, 4'd1, 1'b1);
    recv(4'd9, 3'd0, "chain_next");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
